ptp_ts_fifo: RTL and testbench

- Egress timestamp buffer sitting directly downstream of the PTP transmit frame parser.
- Captures the 80-bit RTC timestamp, 16-bit sequenceId and 4-bit messageType of each transmitted PTP event frame on a one-cycle strobe.
- Holds the captures in a small first-word-fall-through FIFO until host-interface software pops them.
- Counts and flags captures dropped because the FIFO was full.

---
 rtl/ptp_ts_fifo.sv | 145 ++++++++++++++
 tb/tb_ptp_ts_fifo.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ptp_ts_fifo.sv
// Purpose : egress PTP timestamp buffer; captures {ts, sequenceId, messageType} on a
//           one-cycle strobe from the TX frame parser and holds them in a FWFT FIFO for host pops.
// Latency : a capture into an empty FIFO appears on rd_* (rd_valid=1) one cycle after ts_valid.
// Backpres: none upstream; a capture arriving while full (and not popped that cycle) is dropped,
//           sets ovf_sticky and bumps the saturating ovf_count.
// Ports   : clk/rst         - single clock, async active-high reset
//           ts_*            - capture strobe and payload from the TX frame parser
//           rd_req          - pop strobe from host interface; rd_* show the head entry
//           flush / ovf_clr - discard all entries / clear overflow status
//           level/full      - occupancy 0..DEPTH and full flag
//           ovf_sticky/ovf_count/irq - drop status and registered interrupt
module ptp_ts_fifo #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 2,
   parameter int TS_W   = 80
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ts_valid,
   input  logic [TS_W-1:0]   ts_value,
   input  logic [15:0]       ts_seq_id,
   input  logic [3:0]        ts_msg_type,
   input  logic              rd_req,
   input  logic              flush,
   input  logic              ovf_clr,
   output logic              rd_valid,
   output logic [TS_W-1:0]   rd_ts,
   output logic [15:0]       rd_seq_id,
   output logic [3:0]        rd_msg_type,
   output logic [ADDR_W:0]   level,
   output logic              full,
   output logic              ovf_sticky,
   output logic [7:0]        ovf_count,
   output logic              irq
);

   typedef struct packed {
      logic [TS_W-1:0] ts;
      logic [15:0]     seq_id;
      logic [3:0]      msg_type;
   } entry_t;

   localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W+1)'(DEPTH);

   entry_t              r_mem [DEPTH];
   logic [ADDR_W-1:0]   r_wr_ptr;
   logic [ADDR_W-1:0]   r_rd_ptr;
   logic [ADDR_W:0]     r_level;
   logic                r_ovf_sticky;
   logic [7:0]          r_ovf_count;
   logic                r_irq;

   logic                w_empty;
   logic                w_full;
   logic                w_do_wr;
   logic                w_do_rd;
   logic                w_ovf;
   logic [ADDR_W-1:0]   w_wr_ptr_nxt;
   logic [ADDR_W-1:0]   w_rd_ptr_nxt;
   logic [ADDR_W:0]     w_level_nxt;
   logic                w_ovf_sticky_nxt;
   logic [7:0]          w_ovf_count_nxt;
   entry_t              w_wr_entry;
   entry_t              w_head;

   always_comb begin
      w_empty = (r_level == '0);
      w_full  = (r_level == LVL_FULL);
      // flush overrides everything; a pop on a full FIFO frees the slot the write needs
      w_do_rd = rd_req & ~flush & ~w_empty;
      w_do_wr = ts_valid & ~flush & (~w_full | rd_req);
      w_ovf   = ts_valid & ~flush & w_full & ~rd_req;

      w_wr_ptr_nxt = r_wr_ptr;
      w_rd_ptr_nxt = r_rd_ptr;
      w_level_nxt  = r_level;
      if (flush) begin
         w_wr_ptr_nxt = '0;
         w_rd_ptr_nxt = '0;
         w_level_nxt  = '0;
      end else begin
         if (w_do_wr) w_wr_ptr_nxt = r_wr_ptr + 1'b1;
         if (w_do_rd) w_rd_ptr_nxt = r_rd_ptr + 1'b1;
         w_level_nxt = r_level + (ADDR_W+1)'(w_do_wr) - (ADDR_W+1)'(w_do_rd);
      end

      // A drop in the same cycle as ovf_clr wins: status restarts at one drop
      w_ovf_sticky_nxt = r_ovf_sticky;
      w_ovf_count_nxt  = r_ovf_count;
      if (w_ovf) begin
         w_ovf_sticky_nxt = 1'b1;
         if (ovf_clr)                    w_ovf_count_nxt = 8'd1;
         else if (r_ovf_count != 8'hFF)  w_ovf_count_nxt = r_ovf_count + 8'd1;
      end else if (ovf_clr) begin
         w_ovf_sticky_nxt = 1'b0;
         w_ovf_count_nxt  = 8'd0;
      end
   end

   always_comb begin
      w_wr_entry.ts       = ts_value;
      w_wr_entry.seq_id   = ts_seq_id;
      w_wr_entry.msg_type = ts_msg_type;
   end

   // Payload storage carries no reset; contents are only observed through r_level gating
   always_ff @(posedge clk) begin
      if (w_do_wr) r_mem[r_wr_ptr] <= w_wr_entry;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_level      <= '0;
         r_ovf_sticky <= 1'b0;
         r_ovf_count  <= 8'd0;
         r_irq        <= 1'b0;
      end else begin
         r_wr_ptr     <= w_wr_ptr_nxt;
         r_rd_ptr     <= w_rd_ptr_nxt;
         r_level      <= w_level_nxt;
         r_ovf_sticky <= w_ovf_sticky_nxt;
         r_ovf_count  <= w_ovf_count_nxt;
         // Built from next-state so irq rises in the same cycle as rd_valid
         r_irq        <= (w_level_nxt != '0) | w_ovf_sticky_nxt;
      end
   end

   always_comb begin
      w_head = r_mem[r_rd_ptr];
      if (w_empty) w_head = '0;
   end

   assign rd_valid    = ~w_empty;
   assign rd_ts       = w_head.ts;
   assign rd_seq_id   = w_head.seq_id;
   assign rd_msg_type = w_head.msg_type;
   assign level       = r_level;
   assign full        = w_full;
   assign ovf_sticky  = r_ovf_sticky;
   assign ovf_count   = r_ovf_count;
   assign irq         = r_irq;

endmodule

// File: tb/tb_ptp_ts_fifo.sv
module tb_ptp_ts_fifo;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ts_valid = 1'b0;
   logic [79:0] ts_value = '0;
   logic [15:0] ts_seq_id = '0;
   logic [3:0]  ts_msg_type = '0;
   logic        rd_req = 1'b0;
   logic        flush = 1'b0;
   logic        ovf_clr = 1'b0;
   logic        rd_valid;
   logic [79:0] rd_ts;
   logic [15:0] rd_seq_id;
   logic [3:0]  rd_msg_type;
   logic [2:0]  level;
   logic        full;
   logic        ovf_sticky;
   logic [7:0]  ovf_count;
   logic        irq;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct packed {
      logic [79:0] ts;
      logic [15:0] seq;
      logic [3:0]  typ;
   } ent_t;

   // Reference model: a queue of pending captures plus overflow status
   ent_t m_q[$];
   bit   m_sticky;
   int   m_count;

   ptp_ts_fifo #(.DEPTH(4), .ADDR_W(2), .TS_W(80)) dut (
      .clk(clk), .rst(rst),
      .ts_valid(ts_valid), .ts_value(ts_value), .ts_seq_id(ts_seq_id), .ts_msg_type(ts_msg_type),
      .rd_req(rd_req), .flush(flush), .ovf_clr(ovf_clr),
      .rd_valid(rd_valid), .rd_ts(rd_ts), .rd_seq_id(rd_seq_id), .rd_msg_type(rd_msg_type),
      .level(level), .full(full), .ovf_sticky(ovf_sticky), .ovf_count(ovf_count), .irq(irq)
   );

   always #5 clk = ~clk;

   // Drives one clock cycle of stimulus (called at negedge) and advances the model at the edge.
   task automatic cycle(input bit tv, input logic [79:0] ts, input logic [15:0] sq,
                        input logic [3:0] ty, input bit rr, input bit fl, input bit oc);
      bit pop, wr, ovf;
      ent_t e;
      ts_valid = tv; ts_value = ts; ts_seq_id = sq; ts_msg_type = ty;
      rd_req = rr; flush = fl; ovf_clr = oc;
      @(posedge clk);
      e.ts = ts; e.seq = sq; e.typ = ty;
      if (fl) begin
         m_q.delete();
         ovf = 1'b0;
      end else begin
         pop = rr && (m_q.size() > 0);
         wr  = tv && (m_q.size() < DEPTH || pop);
         ovf = tv && m_q.size() == DEPTH && !rr;
         if (pop) void'(m_q.pop_front());
         if (wr)  m_q.push_back(e);
      end
      if (ovf) begin
         m_sticky = 1'b1;
         m_count  = oc ? 1 : (m_count < 255 ? m_count + 1 : 255);
      end else if (oc) begin
         m_sticky = 1'b0;
         m_count  = 0;
      end
      @(negedge clk);
      ts_valid = 1'b0; rd_req = 1'b0; flush = 1'b0; ovf_clr = 1'b0;
   endtask

   task automatic wr_seq(input logic [15:0] sq);
      cycle(1'b1, {48'd0, 16'h0, sq}, sq, sq[3:0], 1'b0, 1'b0, 1'b0);
   endtask

   task automatic pop_one();
      cycle(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      m_q.delete(); m_sticky = 0; m_count = 0;
      @(negedge clk);
      n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
      n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL reset_level got %0d want 0", level); end
      n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b want 0", full); end
      n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got %b want 0", irq); end
      n_cmp++; if (ovf_sticky !== 1'b0 || ovf_count !== 8'd0) begin n_err++; $display("FAIL reset_ovf got %b/%0d want 0/0", ovf_sticky, ovf_count); end
      n_cmp++; if (rd_ts !== 80'd0 || rd_seq_id !== 16'd0 || rd_msg_type !== 4'd0) begin n_err++; $display("FAIL reset_rd_data got %h/%h/%h want 0", rd_ts, rd_seq_id, rd_msg_type); end
   endtask

   task automatic test_first_write();
      cycle(1'b1, 80'h0000_0000_0005_1234_5678, 16'h0010, 4'h0, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (rd_valid !== 1'b1 || level !== 3'd1 || irq !== 1'b1) begin n_err++; $display("FAIL first_wr_status got v=%b l=%0d irq=%b want 1/1/1", rd_valid, level, irq); end
      n_cmp++; if (rd_ts !== 80'h0000_0000_0005_1234_5678) begin n_err++; $display("FAIL first_wr_ts got %h want 51234_5678", rd_ts); end
      n_cmp++; if (rd_seq_id !== 16'h0010) begin n_err++; $display("FAIL first_wr_seq got %h want 0010", rd_seq_id); end
      pop_one();
      n_cmp++; if (rd_valid !== 1'b0 || irq !== 1'b0 || rd_seq_id !== 16'h0) begin n_err++; $display("FAIL first_pop_empty got v=%b irq=%b seq=%h want 0/0/0", rd_valid, irq, rd_seq_id); end
   endtask

   task automatic test_overflow();
      for (int i = 1; i <= 4; i++) wr_seq(16'(i));
      wr_seq(16'd5);
      n_cmp++; if (full !== 1'b1 || ovf_sticky !== 1'b1 || ovf_count !== 8'd1) begin n_err++; $display("FAIL ovf_status got f=%b s=%b c=%0d want 1/1/1", full, ovf_sticky, ovf_count); end
      for (int i = 1; i <= 4; i++) begin
         n_cmp++; if (rd_seq_id !== 16'(i)) begin n_err++; $display("FAIL ovf_pop_order got %0d want %0d", rd_seq_id, i); end
         pop_one();
      end
      n_cmp++; if (level !== 3'd0 || rd_valid !== 1'b0 || irq !== 1'b1) begin n_err++; $display("FAIL ovf_drained got l=%0d v=%b irq=%b want 0/0/1", level, rd_valid, irq); end
      cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
      n_cmp++; if (irq !== 1'b0 || ovf_sticky !== 1'b0 || ovf_count !== 8'd0) begin n_err++; $display("FAIL ovf_clr got irq=%b s=%b c=%0d want 0/0/0", irq, ovf_sticky, ovf_count); end
   endtask

   task automatic test_full_wr_rd();
      for (int i = 1; i <= 4; i++) wr_seq(16'(i));
      cycle(1'b1, 80'h9, 16'd9, 4'h9, 1'b1, 1'b0, 1'b0);
      n_cmp++; if (ovf_count !== 8'd0 || level !== 3'd4) begin n_err++; $display("FAIL full_wr_rd got c=%0d l=%0d want 0/4", ovf_count, level); end
      n_cmp++; if (rd_seq_id !== 16'd2) begin n_err++; $display("FAIL full_wr_rd_head got %0d want 2", rd_seq_id); end
      pop_one(); pop_one(); pop_one();
      n_cmp++; if (rd_seq_id !== 16'd9 || rd_msg_type !== 4'h9) begin n_err++; $display("FAIL full_wr_rd_4th got %0d/%h want 9/9", rd_seq_id, rd_msg_type); end
      pop_one();
   endtask

   task automatic test_empty_wr_rd();
      cycle(1'b1, 80'h7, 16'd7, 4'h3, 1'b1, 1'b0, 1'b0);
      n_cmp++; if (level !== 3'd1 || rd_seq_id !== 16'd7) begin n_err++; $display("FAIL empty_wr_rd got l=%0d seq=%0d want 1/7", level, rd_seq_id); end
      pop_one();
   endtask

   task automatic test_saturate();
      for (int i = 1; i <= 4; i++) wr_seq(16'(i));
      for (int i = 0; i < 300; i++) wr_seq(16'hBEEF);
      n_cmp++; if (ovf_count !== 8'd255) begin n_err++; $display("FAIL ovf_saturate got %0d want 255", ovf_count); end
      cycle(1'b1, 80'h1, 16'h1, 4'h1, 1'b0, 1'b0, 1'b1);
      n_cmp++; if (ovf_count !== 8'd1 || ovf_sticky !== 1'b1) begin n_err++; $display("FAIL ovf_clr_race got c=%0d s=%b want 1/1", ovf_count, ovf_sticky); end
      n_cmp++; if (rd_seq_id !== 16'd1 || level !== 3'd4) begin n_err++; $display("FAIL ovf_contents got seq=%0d l=%0d want 1/4", rd_seq_id, level); end
   endtask

   task automatic test_flush_and_reset();
      cycle(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
      for (int i = 1; i <= 3; i++) wr_seq(16'(i));
      n_cmp++; if (level !== 3'd3) begin n_err++; $display("FAIL flush_prefill got %0d want 3", level); end
      cycle(1'b1, 80'hA, 16'hA, 4'hA, 1'b0, 1'b1, 1'b0);
      n_cmp++; if (level !== 3'd0 || rd_valid !== 1'b0) begin n_err++; $display("FAIL flush got l=%0d v=%b want 0/0", level, rd_valid); end
      n_cmp++; if (ovf_sticky !== 1'b1 || ovf_count !== 8'd1) begin n_err++; $display("FAIL flush_ovf got s=%b c=%0d want 1/1", ovf_sticky, ovf_count); end
      wr_seq(16'd1); wr_seq(16'd2);
      ts_valid = 1'b1; ts_seq_id = 16'd3;
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (rd_valid !== 1'b0 || level !== 3'd0 || irq !== 1'b0 || full !== 1'b0) begin n_err++; $display("FAIL async_rst got v=%b l=%0d irq=%b f=%b want 0", rd_valid, level, irq, full); end
      n_cmp++; if (ovf_sticky !== 1'b0 || ovf_count !== 8'd0 || rd_seq_id !== 16'd0 || rd_ts !== 80'd0) begin n_err++; $display("FAIL async_rst_data got s=%b c=%0d seq=%h want 0", ovf_sticky, ovf_count, rd_seq_id); end
      @(negedge clk);
      ts_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      m_q.delete(); m_sticky = 0; m_count = 0;
      @(negedge clk);
   endtask

   task automatic test_random();
      bit tv, rr, fl, oc;
      ent_t h;
      for (int n = 0; n < 1500; n++) begin
         tv = ($urandom_range(99) < 55);
         rr = ($urandom_range(99) < 45);
         fl = ($urandom_range(99) < 3);
         oc = ($urandom_range(99) < 5);
         cycle(tv, {$urandom, $urandom, 16'($urandom)}, 16'($urandom), 4'($urandom), rr, fl, oc);
         h = (m_q.size() > 0) ? m_q[0] : '0;
         n_cmp++; if (level !== 3'(m_q.size()) || rd_valid !== (m_q.size() > 0) || full !== (m_q.size() == DEPTH)) begin
            n_err++; $display("FAIL rnd_level cyc %0d got l=%0d v=%b f=%b want l=%0d", n, level, rd_valid, full, m_q.size()); end
         n_cmp++; if ({rd_ts, rd_seq_id, rd_msg_type} !== h) begin
            n_err++; $display("FAIL rnd_head cyc %0d got %h/%h/%h want %h/%h/%h", n, rd_ts, rd_seq_id, rd_msg_type, h.ts, h.seq, h.typ); end
         n_cmp++; if (ovf_sticky !== m_sticky || ovf_count !== 8'(m_count)) begin
            n_err++; $display("FAIL rnd_ovf cyc %0d got s=%b c=%0d want s=%b c=%0d", n, ovf_sticky, ovf_count, m_sticky, m_count); end
         n_cmp++; if (irq !== ((m_q.size() > 0) || m_sticky)) begin
            n_err++; $display("FAIL rnd_irq cyc %0d got %b", n, irq); end
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_first_write();
      test_overflow();
      test_full_wr_rd();
      test_empty_wr_rd();
      test_saturate();
      test_flush_and_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
